// File: rtl/rom2ram_copier.sv
// Block copy engine: moves len words from ROM to RAM while holding arbiter channel 0.
// Optional feature macro ROM2RAM_CHECKSUM_EN adds a modulo-2^DATA_W sum of written words.

module rom2ram_copier #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
`ifdef ROM2RAM_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PRIME,
        S_COPY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_wr_cnt;
    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_dst;
    logic [ADDR_W:0]   w_len;
    logic [ADDR_W:0]   w_rd_cnt;
    logic [ADDR_W:0]   w_wr_cnt;

    // Word address = base + offset, wrapping at the top of memory.
    function automatic logic [ADDR_W-1:0] addr_wrap(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W:0]   offs);
        return base + offs[ADDR_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_src    <= w_src;
            r_dst    <= w_dst;
            r_len    <= w_len;
            r_rd_cnt <= w_rd_cnt;
            r_wr_cnt <= w_wr_cnt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_src     = r_src;
        w_dst     = r_dst;
        w_len     = r_len;
        w_rd_cnt  = r_rd_cnt;
        w_wr_cnt  = r_wr_cnt;
        req       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        ram_we    = 1'b0;
        rom_addr  = '0;
        ram_addr  = '0;
        ram_wdata = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src    = src_base;
                    w_dst    = dst_base;
                    w_len    = len;
                    w_rd_cnt = '0;
                    w_wr_cnt = '0;
                    w_next   = (len == '0) ? S_DONE : S_REQ;
                end
            end

            S_REQ: begin
                req  = 1'b1;
                busy = 1'b1;
                // Restart reads at the first unwritten word; covers both the
                // initial grant and any re-grant after a loss.
                if (gnt) begin
                    w_rd_cnt = r_wr_cnt;
                    w_next   = S_PRIME;
                end
            end

            S_PRIME: begin
                req      = 1'b1;
                busy     = 1'b1;
                rom_addr = addr_wrap(r_src, r_rd_cnt);
                if (gnt) begin
                    w_rd_cnt = r_rd_cnt + 1'b1;
                    w_next   = S_COPY;
                end else begin
                    w_next = S_REQ;
                end
            end

            S_COPY: begin
                req      = 1'b1;
                busy     = 1'b1;
                rom_addr = addr_wrap(r_src, r_rd_cnt);
                // A write is only committed while the grant is actually held.
                if (gnt) begin
                    ram_we    = 1'b1;
                    ram_addr  = addr_wrap(r_dst, r_wr_cnt);
                    ram_wdata = rom_data;
                    w_wr_cnt  = r_wr_cnt + 1'b1;
                    if (r_rd_cnt < r_len) begin
                        w_rd_cnt = r_rd_cnt + 1'b1;
                    end
                    if (r_wr_cnt == r_len - 1'b1) begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_next = S_REQ;
                end
            end

            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef ROM2RAM_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_checksum <= '0;
        end else if (ram_we) begin
            r_checksum <= r_checksum + ram_wdata;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_rom2ram_copier.sv
// Bench for rom2ram_copier: ROM/RAM/arbiter models plus an address-level copy model.

module tb_rom2ram_copier;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW:0]   len;
    logic          req;
    logic          gnt;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          busy;
    logic          done;
`ifdef ROM2RAM_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    rom2ram_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .len       (len),
        .req       (req),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
`ifdef ROM2RAM_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done)
    );

    // Synchronous ROM with one cycle of read latency
    logic [DW-1:0] rom [DEPTH];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Arbiter: grants one cycle after req, withheld while hold is set
    logic hold;
    always @(posedge clk) begin
        if (reset) gnt <= 1'b0;
        else       gnt <= req && !hold;
    end

    // Monitor: RAM image, per-address write counts and event timestamps
    logic          mon_clr;
    int            cyc = 0;
    int            wr_seen, req_seen, done_cnt, bad_we, busy_noreq, we_outside;
    int            first_we, last_we, gnt_rise, done_cyc, start_cyc;
    logic          req_at_done, busy_at_done;
    logic [DW-1:0] ram_m [DEPTH];
    int            wcnt [DEPTH];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            wr_seen    <= 0;
            req_seen   <= 0;
            done_cnt   <= 0;
            bad_we     <= 0;
            busy_noreq <= 0;
            we_outside <= 0;
            first_we   <= -1;
            last_we    <= -1;
            gnt_rise   <= -1;
            done_cyc   <= -1;
            start_cyc  <= -1;
            for (int i = 0; i < DEPTH; i++) wcnt[i] <= 0;
        end else begin
            if (start) start_cyc <= cyc;
            if (req) req_seen <= req_seen + 1;
            if (gnt && gnt_rise < 0) gnt_rise <= cyc;
            if (busy && !req) busy_noreq <= busy_noreq + 1;
            if (ram_we) begin
                wr_seen        <= wr_seen + 1;
                wcnt[ram_addr] <= wcnt[ram_addr] + 1;
                ram_m[ram_addr] <= ram_wdata;
                if (first_we < 0) first_we <= cyc;
                last_we <= cyc;
                if (!gnt) bad_we <= bad_we + 1;
                if (!busy || !req) we_outside <= we_outside + 1;
            end
            if (done) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc;
                req_at_done  <= req;
                busy_at_done <= busy;
            end
        end
    end

    // Reference model: what a copy of n words from s to d leaves in RAM
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            exp_wr [DEPTH];
    logic [DW-1:0] exp_ram [DEPTH];
    logic [DW-1:0] exp_sum;

    function automatic void build_expect(input int s, input int d, input int n);
        for (int a = 0; a < DEPTH; a++) begin
            exp_wr[a]  = 0;
            exp_ram[a] = '0;
        end
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_wr[(d + i) % DEPTH]  = 1;
            exp_ram[(d + i) % DEPTH] = rom[(s + i) % DEPTH];
            exp_sum = exp_sum + rom[(s + i) % DEPTH];
        end
    endfunction

    function automatic void fill_rom_random();
        for (int a = 0; a < DEPTH; a++) rom[a] = DW'($urandom);
    endfunction

    task automatic launch(input int s, input int d, input int n);
        @(posedge clk); #1;
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr  = 1'b0;
        src_base = AW'(s);
        dst_base = AW'(d);
        len      = (AW+1)'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; hold = 1'b0; mon_clr = 1'b1;
        src_base = '0; dst_base = '0; len = '0;
        for (int a = 0; a < DEPTH; a++) rom[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({req, busy, done, ram_we} !== 4'b0000) $display("FAIL reset_ctrl: req/busy/done/we=%b required 0000", {req, busy, done, ram_we});
        else pass_cnt++;
        total_cnt++;
        if (rom_addr !== '0) $display("FAIL reset_rom_addr: got %h required 0", rom_addr);
        else pass_cnt++;
        total_cnt++;
        if (ram_addr !== '0) $display("FAIL reset_ram_addr: got %h required 0", ram_addr);
        else pass_cnt++;
        total_cnt++;
        if (ram_wdata !== '0) $display("FAIL reset_ram_wdata: got %h required 0", ram_wdata);
        else pass_cnt++;
`ifdef ROM2RAM_CHECKSUM_EN
        total_cnt++;
        if (checksum !== '0) $display("FAIL reset_checksum: got %h required 0", checksum);
        else pass_cnt++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic;
        bit ok;
        for (int a = 0; a < DEPTH; a++) rom[a] = DW'(8'h10 + a);
        build_expect(0, 4, 4);
        launch(0, 4, 4);
        wait_done(40, ok);
        total_cnt++;
        if (!ok) $display("FAIL basic_done_timeout: done seen=%0d required 1", done_cnt);
        else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            total_cnt++;
            if (wcnt[a] != exp_wr[a] || (exp_wr[a] == 1 && ram_m[a] !== exp_ram[a]))
                $display("FAIL basic_ram[%0d]: writes=%0d data=%h required writes=%0d data=%h", a, wcnt[a], ram_m[a], exp_wr[a], exp_ram[a]);
            else pass_cnt++;
        end
        total_cnt++;
        if (first_we - gnt_rise != 2) $display("FAIL basic_latency: first write %0d cycles after grant required 2", first_we - gnt_rise);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc != last_we + 1) $display("FAIL basic_done_timing: done cycle %0d last write %0d required last+1", done_cyc, last_we);
        else pass_cnt++;
        total_cnt++;
        if (req_at_done !== 1'b0 || busy_at_done !== 1'b0) $display("FAIL basic_done_req: req=%b busy=%b in done cycle required 0 0", req_at_done, busy_at_done);
        else pass_cnt++;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (done_cnt != 1 || req !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after_done: done pulses=%0d req=%b busy=%b required 1 0 0", done_cnt, req, busy);
        else pass_cnt++;
`ifdef ROM2RAM_CHECKSUM_EN
        total_cnt++;
        if (checksum !== exp_sum) $display("FAIL basic_checksum: got %h required %h", checksum, exp_sum);
        else pass_cnt++;
`endif
    endtask

    task automatic test_len_zero;
        bit ok;
        fill_rom_random();
        launch($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 0);
        wait_done(5, ok);
        total_cnt++;
        if (!ok || done_cyc != start_cyc + 1) $display("FAIL len0_done: done at %0d start at %0d required start+1", done_cyc, start_cyc);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (req_seen != 0 || wr_seen != 0) $display("FAIL len0_quiet: req cycles=%0d writes=%0d required 0 0", req_seen, wr_seen);
        else pass_cnt++;
`ifdef ROM2RAM_CHECKSUM_EN
        total_cnt++;
        if (checksum !== '0) $display("FAIL len0_checksum: got %h required 0", checksum);
        else pass_cnt++;
`endif
    endtask

    task automatic test_wrap;
        bit ok;
        fill_rom_random();
        build_expect(14, 15, 3);
        launch(14, 15, 3);
        wait_done(40, ok);
        total_cnt++;
        if (!ok || wr_seen != 3) $display("FAIL wrap_done: done=%0d writes=%0d required 1 3", done_cnt, wr_seen);
        else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            total_cnt++;
            if (wcnt[a] != exp_wr[a] || (exp_wr[a] == 1 && ram_m[a] !== exp_ram[a]))
                $display("FAIL wrap_ram[%0d]: writes=%0d data=%h required writes=%0d data=%h", a, wcnt[a], ram_m[a], exp_wr[a], exp_ram[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_grant_loss;
        bit ok;
        bit dropped;
        int drop_t;
        int s, d;
        fill_rom_random();
        s = $urandom_range(0, DEPTH-1);
        d = $urandom_range(0, DEPTH-1);
        build_expect(s, d, 8);
        hold = 1'b1;
        launch(s, d, 8);
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (req !== 1'b1 || wr_seen != 0) $display("FAIL gloss_withheld: req=%b writes=%0d required 1 0", req, wr_seen);
        else pass_cnt++;
        hold = 1'b0;
        ok = 1'b0; dropped = 1'b0; drop_t = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!dropped && wr_seen == 3) begin
                hold = 1'b1; drop_t = 3; dropped = 1'b1;
            end else if (drop_t > 0) begin
                drop_t--;
                if (drop_t == 0) hold = 1'b0;
            end
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        hold = 1'b0;
        total_cnt++;
        if (!ok || wr_seen != 8) $display("FAIL gloss_done: done=%0d writes=%0d required 1 8", done_cnt, wr_seen);
        else pass_cnt++;
        total_cnt++;
        if (bad_we != 0 || busy_noreq != 0 || we_outside != 0) $display("FAIL gloss_protocol: writes without grant=%0d busy without req=%0d stray writes=%0d required 0", bad_we, busy_noreq, we_outside);
        else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            total_cnt++;
            if (wcnt[a] != exp_wr[a] || (exp_wr[a] == 1 && ram_m[a] !== exp_ram[a]))
                $display("FAIL gloss_ram[%0d]: writes=%0d data=%h required writes=%0d data=%h", a, wcnt[a], ram_m[a], exp_wr[a], exp_ram[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int wr_at_reset;
        int s, d, n;
        fill_rom_random();
        launch($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 6);
        for (int i = 0; i < 40; i++) begin
            if (wr_seen >= 2) break;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        wr_at_reset = wr_seen;
        total_cnt++;
        if (req !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) $display("FAIL rstmid_outputs: req=%b busy=%b we=%b required 0 0 0", req, busy, ram_we);
        else pass_cnt++;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total_cnt++;
        if (wr_seen != wr_at_reset || done_cnt != 0) $display("FAIL rstmid_quiet: writes %0d->%0d done=%0d required no change and 0", wr_at_reset, wr_seen, done_cnt);
        else pass_cnt++;
        s = $urandom_range(0, DEPTH-1);
        d = $urandom_range(0, DEPTH-1);
        n = $urandom_range(1, DEPTH);
        build_expect(s, d, n);
        launch(s, d, n);
        wait_done(60, ok);
        total_cnt++;
        if (!ok || wr_seen != n) $display("FAIL rstmid_restart: done=%0d writes=%0d required 1 %0d", done_cnt, wr_seen, n);
        else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            total_cnt++;
            if (wcnt[a] != exp_wr[a] || (exp_wr[a] == 1 && ram_m[a] !== exp_ram[a]))
                $display("FAIL rstmid_ram[%0d]: writes=%0d data=%h required writes=%0d data=%h", a, wcnt[a], ram_m[a], exp_wr[a], exp_ram[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy;
        bit ok;
        int s, d;
        fill_rom_random();
        s = $urandom_range(0, DEPTH-1);
        d = $urandom_range(0, DEPTH-1);
        rom[s % DEPTH]       = 8'd1;
        rom[(s + 1) % DEPTH] = 8'd2;
        rom[(s + 2) % DEPTH] = 8'd3;
        rom[(s + 3) % DEPTH] = 8'd250;
        build_expect(s, d, 4);
        launch(s, d, 4);
        src_base = AW'(s + 8);
        dst_base = AW'(d + 8);
        len      = (AW+1)'(2);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, ok);
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (!ok || done_cnt != 1 || wr_seen != 4) $display("FAIL busy_start: done pulses=%0d writes=%0d required 1 4", done_cnt, wr_seen);
        else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            total_cnt++;
            if (wcnt[a] != exp_wr[a] || (exp_wr[a] == 1 && ram_m[a] !== exp_ram[a]))
                $display("FAIL busy_ram[%0d]: writes=%0d data=%h required writes=%0d data=%h", a, wcnt[a], ram_m[a], exp_wr[a], exp_ram[a]);
            else pass_cnt++;
        end
`ifdef ROM2RAM_CHECKSUM_EN
        total_cnt++;
        if (checksum !== 8'h00) $display("FAIL busy_checksum: got %h required 00", checksum);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random;
        bit ok;
        int s, d, n;
        for (int it = 0; it < 6; it++) begin
            fill_rom_random();
            s = $urandom_range(0, DEPTH-1);
            d = $urandom_range(0, DEPTH-1);
            n = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
            build_expect(s, d, n);
            launch(s, d, n);
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #1;
                hold = ($urandom_range(0, 3) == 0);
                if (done_cnt > 0) begin
                    ok = 1'b1;
                    break;
                end
            end
            hold = 1'b0;
            total_cnt++;
            if (!ok || wr_seen != n || bad_we != 0 || we_outside != 0)
                $display("FAIL rand%0d_xfer: done=%0d writes=%0d required %0d, ungranted=%0d stray=%0d", it, done_cnt, wr_seen, n, bad_we, we_outside);
            else pass_cnt++;
            for (int a = 0; a < DEPTH; a++) begin
                total_cnt++;
                if (wcnt[a] != exp_wr[a] || (exp_wr[a] == 1 && ram_m[a] !== exp_ram[a]))
                    $display("FAIL rand%0d_ram[%0d]: writes=%0d data=%h required writes=%0d data=%h", it, a, wcnt[a], ram_m[a], exp_wr[a], exp_ram[a]);
                else pass_cnt++;
            end
`ifdef ROM2RAM_CHECKSUM_EN
            total_cnt++;
            if (checksum !== exp_sum) $display("FAIL rand%0d_checksum: got %h required %h", it, checksum, exp_sum);
            else pass_cnt++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_grant_loss();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", pass_cnt, total_cnt);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/rom2ram_copier.md
Name: rom2ram_copier

Overview:
- DMA-style copy engine that moves a block of words from the coefficient ROM into working RAM ahead of the dot-product stage.
- Owns the arbiter's channel 0: drives request `r0` and consumes grant `g0`. It holds the request for the entire transfer and drops it when the transfer is done.
- Started by the top-level controller. Reports completion with a one-cycle `done` pulse.

Parameters:
- ADDR_W, 4, width of ROM and RAM word addresses
- DATA_W, 8, width of a data word

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; launches a copy when idle
- src_base  input  ADDR_W  first ROM address, latched on start
- dst_base  input  ADDR_W  first RAM address, latched on start
- len  input  ADDR_W+1  number of words to copy (0..2^ADDR_W), latched on start
- req  output  1  request to arbiter (drives r0)
- gnt  input  1  grant from arbiter (g0)
- rom_addr  output  ADDR_W  ROM read address; ROM is synchronous with 1-cycle read latency
- rom_data  input  DATA_W  ROM read data, valid the cycle after rom_addr
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_W  RAM write address
- ram_wdata  output  DATA_W  RAM write data
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values: state IDLE; `req`, `ram_we`, `busy`, `done` = 0; `rom_addr`, `ram_addr`, `ram_wdata` = 0; internal counters = 0.
- State IDLE:
  - `start` with `len` != 0: latch the inputs, go to REQ.
  - `start` with `len` == 0: go to DONE. `req` is never raised.
- State REQ:
  - `req` = 1.
  - Stays in REQ while `gnt` = 0.
  - `gnt` = 1: go to PRIME.
- State PRIME:
  - `req` = 1, `rom_addr` = `src_base` + `rd_cnt`.
  - Next cycle: go to COPY with `rd_cnt` incremented.
- State COPY, one word per cycle:
  - `ram_we` = 1, `ram_addr` = `dst_base` + `wr_cnt`, `ram_wdata` = `rom_data`.
  - `rom_addr` advances to `src_base` + `rd_cnt` while reads remain.
  - Throughput is 1 word per cycle. Latency is 2 cycles from grant seen to the first RAM write.
- End of COPY: when `wr_cnt` reaches `len`-1 and that word is written, go to DONE.
- State DONE:
  - `done` = 1 for exactly one cycle, `req` = 0, `busy` = 0. Return to IDLE.
  - The arbiter drops `g0` one cycle later.
- Address arithmetic: modulo 2^ADDR_W. Copies that cross the top of memory wrap to address 0.
- Counters: ADDR_W+1 bits wide, so `len` = 2^ADDR_W copies the full memory.
- Grant loss in PRIME/COPY:
  - Next edge: `ram_we` = 0, counters frozen, `req` held at 1.
  - When `gnt` returns: re-enter PRIME for the first unwritten word. No word is skipped or written twice with stale data.
- Ignored inputs:
  - `start` while `busy` is ignored.
  - `gnt` is ignored in IDLE and DONE, which covers the lingering `g0` after `req` drops.
- Reset mid-transfer: aborts the transfer. All outputs return to reset values on the next edge and `done` is not pulsed.
- Write address range: `ram_we` is never asserted outside COPY, and never for more than `len` distinct addresses.

Optional Feature:
- Macro: ROM2RAM_CHECKSUM_EN.
- When defined:
  - Adds output `checksum` (DATA_W wide), the modulo-2^DATA_W sum of every word written during the last transfer.
  - Cleared to 0 on accepted start and on reset.
  - Final value is stable from the cycle `done` pulses until the next start.
- When undefined: no `checksum` port and no adder logic.

Test Plan:
- ROM[i]=i+8'h10, `start` with `src_base`=0, `dst_base`=4, `len`=4, `gnt` returned 1 cycle after `req` -> RAM[4..7]=10,11,12,13. First `ram_we` 2 cycles after `gnt`; `done` pulses 1 cycle after the last write; `req` low in the `done` cycle.
- `len`=0 -> `done` 1 cycle after `start`; `req` and `ram_we` never assert.
- `src_base`=14, `dst_base`=15, `len`=3, ADDR_W=4 -> reads ROM 14,15,0 and writes RAM 15,0,1.
- `gnt` withheld for 10 cycles, then dropped for 3 cycles mid-copy (`len`=8) -> no writes while `gnt`=0, `req` held high, all 8 RAM words correct, each address written once with correct data.
- Reset asserted on the 3rd write of `len`=6 -> next edge: `req`=0, `busy`=0, no further writes, no `done`. A new `start` then completes normally.
- `start` re-pulsed while `busy`; with ROM2RAM_CHECKSUM_EN, words 1,2,3,250 -> second `start` ignored; `checksum`=8'h00 at `done`.
